// File: rtl/stall_unit.sv
// Load-use hazard detector for the ID stage: stalls PC and IF/ID and bubbles ID/EX
// for one cycle when a source register is the destination of the load in ID/EX.
// Optional saturating stall counter enabled by defining STALL_UNIT_CNT_EN.
module stall_unit #(
    parameter logic [1:0] ALU   = 2'b00,
    parameter logic [1:0] MEM   = 2'b01,
    parameter logic [1:0] PC4   = 2'b10,
    parameter int         CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       reg_rs1_addr_i,
    input  logic [4:0]       reg_rs2_addr_i,
    input  logic [4:0]       id_ex_reg_wr_addr_i,
    input  logic             id_ex_reg_wr_sig_i,
    input  logic [1:0]       id_ex_data_dest_i,
    output logic             stall_o,
    output logic             pc_wr_en_o,
    output logic             if_id_wr_en_o,
    output logic             id_ex_flush_o,
`ifdef STALL_UNIT_CNT_EN
    output logic [CNT_W-1:0] stall_count_o,
`endif
    output logic             stall_q_o
);

    logic load_in_ex;
    logic dest_nonzero;
    logic src_match;
    logic stall_q_reg;

    // Only loads stall; ALU and link results reach ID through forwarding.
    // Operands are deliberately not X-masked so undefined inputs stay visible.
    assign load_in_ex   = id_ex_reg_wr_sig_i & (id_ex_data_dest_i == MEM);
    assign dest_nonzero = (id_ex_reg_wr_addr_i != 5'd0);
    assign src_match    = (id_ex_reg_wr_addr_i == reg_rs1_addr_i) |
                          (id_ex_reg_wr_addr_i == reg_rs2_addr_i);

    assign stall_o       = load_in_ex & dest_nonzero & src_match;
    assign pc_wr_en_o    = ~stall_o;
    assign if_id_wr_en_o = ~stall_o;
    assign id_ex_flush_o = stall_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q_reg <= 1'b0;
        end else begin
            stall_q_reg <= stall_o;
        end
    end

    assign stall_q_o = stall_q_reg;

`ifdef STALL_UNIT_CNT_EN
    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] stall_count_next;

    // Saturate at all-ones so a long run never reads back as a small count.
    always_comb begin
        stall_count_next = stall_count_reg;
        if (stall_o && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_next = stall_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_count_reg <= '0;
        end else begin
            stall_count_reg <= stall_count_next;
        end
    end

    assign stall_count_o = stall_count_reg;
`endif

endmodule

// File: tb/tb_stall_unit.sv
// Self-checking bench for stall_unit: directed load-use cases, async reset,
// randomized traffic against a rule-level reference model, counter saturation.
module tb_stall_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, wr_addr;
    logic       wr_sig;
    logic [1:0] dest;
    logic       stall, pc_wr_en, if_id_wr_en, id_ex_flush, stall_q;
`ifdef STALL_UNIT_CNT_EN
    logic [CNT_W-1:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;
    bit exp_q;
    int exp_cnt;

    always #5 clk = ~clk;

    stall_unit #(.CNT_W(CNT_W)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .reg_rs1_addr_i      (rs1),
        .reg_rs2_addr_i      (rs2),
        .id_ex_reg_wr_addr_i (wr_addr),
        .id_ex_reg_wr_sig_i  (wr_sig),
        .id_ex_data_dest_i   (dest),
        .stall_o             (stall),
        .pc_wr_en_o          (pc_wr_en),
        .if_id_wr_en_o       (if_id_wr_en),
        .id_ex_flush_o       (id_ex_flush),
`ifdef STALL_UNIT_CNT_EN
        .stall_count_o       (stall_count),
`endif
        .stall_q_o           (stall_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: a load writing a real register that the ID instruction reads.
    function automatic bit ref_stall(input int s1, input int s2, input int wa,
                                     input bit we, input int dst);
        bit is_load = we && (dst == 1);
        bit reads_it = (wa == s1) || (wa == s2);
        return is_load && (wa != 0) && reads_it;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, ".stall_q"}, {31'd0, stall_q}, {31'd0, exp_q});
`ifdef STALL_UNIT_CNT_EN
        chk({tag, ".count"}, {{(32-CNT_W){1'b0}}, stall_count}, exp_cnt);
`endif
    endtask

    // Drive one ID-stage pattern, check the combinational outputs, clock it in.
    task automatic apply(input string tag, input int s1, input int s2, input int wa,
                         input bit we, input int dst);
        bit s;
        rs1 = 5'(s1); rs2 = 5'(s2); wr_addr = 5'(wa); wr_sig = we; dest = 2'(dst);
        #1;
        s = ref_stall(s1, s2, wa, we, dst);
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
        chk({tag, ".pc_wr_en"}, {31'd0, pc_wr_en}, {31'd0, !s});
        chk({tag, ".if_id_wr_en"}, {31'd0, if_id_wr_en}, {31'd0, !s});
        chk({tag, ".flush"}, {31'd0, id_ex_flush}, {31'd0, s});
        @(posedge clk);
        exp_q = s;
        if (s && exp_cnt < CNT_MAX) exp_cnt++;
        #1;
        check_regs(tag);
        $display("txn %s rs1=%0d rs2=%0d wa=%0d we=%0b dest=%0d stall=%0b stall_q=%0b",
                 tag, s1, s2, wa, we, dst, stall, stall_q);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q = 1'b0; exp_cnt = 0;
        check_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rs1 = 5'd1; rs2 = 5'd2; wr_addr = 5'd3; wr_sig = 1'b0; dest = 2'b00;
        exp_q = 1'b0; exp_cnt = 0;
        #2;
        check_regs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the hazard rule
        apply("no_wr",     1, 2, 3, 1'b0, 0);
        apply("rs1_load",  1, 2, 1, 1'b1, 1);
        apply("rs2_load",  1, 2, 2, 1'b1, 1);
        apply("x0_load",   0, 2, 0, 1'b1, 1);
        apply("x0_both",   0, 0, 0, 1'b1, 1);
        apply("rs1_alu",   1, 2, 1, 1'b1, 0);
        apply("rs1_pc4",   1, 2, 1, 1'b1, 2);
        apply("rs1_d11",   1, 2, 1, 1'b1, 3);
        apply("rs2_nowr",  1, 2, 2, 1'b0, 1);
        apply("load_miss", 1, 2, 31, 1'b1, 1);

        // Three stall cycles from a fresh reset, then reset mid-stall
        do_reset();
        for (int i = 0; i < 3; i++) apply("stall3", 5, 9, 5, 1'b1, 1);
        chk("stall3.count_model", exp_cnt, 3);
        rst_n = 1'b0;
        #1;
        exp_q = 1'b0; exp_cnt = 0;
        check_regs("midreset");
        chk("midreset.stall_ungated", {31'd0, stall}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with a narrow address range to force matches
        for (int i = 0; i < 200; i++) begin
            apply("rand", $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Long stall run drives the counter into saturation
        for (int i = 0; i < CNT_MAX + 4; i++) apply("sat", 7, 0, 7, 1'b1, 1);
        apply("sat_drop", 7, 0, 7, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
